// File: rtl/cosim_constants_pkg.sv
// Shared widths and sizes for the co-simulation commit-log checker.
`timescale 1ns/1ps
package cosim_constants_pkg;
    localparam int unsigned XREG_W           = 32;
    localparam int unsigned FREG_W           = 64;
    localparam int unsigned RegIdW           = 12;
    localparam int unsigned CommitLogEntries = 16;
endpackage

// File: rtl/cosim_pkg.sv
// Commit-log item types, checker FSM states and the item compare rule.
`timescale 1ns/1ps
package cosim_pkg;
    import cosim_constants_pkg::*;

    typedef enum logic [1:0] {
        XREG = 2'd0,
        FREG = 2'd1,
        CSR  = 2'd2
    } reg_key_type_e;

    typedef struct packed {
        reg_key_type_e     reg_type;
        logic [RegIdW-1:0] reg_id;
        logic [FREG_W-1:0] value;
    } commit_log_reg_item_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } cosim_chk_state_e;

    // Integer registers only carry XREG_W meaningful bits; upper bits are don't-care.
    function automatic logic items_match(commit_log_reg_item_t e, commit_log_reg_item_t d,
                                         logic cmp_value);
        logic key_eq;
        logic val_eq;
        key_eq = (e.reg_type == d.reg_type) && (e.reg_id == d.reg_id);
        if (e.reg_type == XREG) val_eq = (e.value[XREG_W-1:0] == d.value[XREG_W-1:0]);
        else                    val_eq = (e.value == d.value);
        return key_eq && (!cmp_value || val_eq);
    endfunction
endpackage

// File: rtl/cosim_log_fifo.sv
// Per-hart circular FIFO of expected commit items; registered head, no bypass.
`timescale 1ns/1ps
module cosim_log_fifo #(
    parameter int unsigned Depth  = 16,
    parameter type         item_t = logic
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  item_t                        item_i,
    input  logic                         pop_i,
    output item_t                        head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   level_o
);
    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned LevelW = $clog2(Depth + 1);

    item_t             mem [Depth];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [LevelW-1:0] level_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (level_q == LevelW'(Depth));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= item_i;
    end

    // Depth is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign head_o  = mem[rd_ptr_q];
    assign level_o = level_q;
endmodule

// File: rtl/cosim_commit_checker.sv
// Compares DUT register-write commits against reference-model expectations per hart,
// halting a hart on its first mismatch and capturing the first failure globally.
`timescale 1ns/1ps
module cosim_commit_checker
    import cosim_constants_pkg::*;
    import cosim_pkg::*;
#(
    parameter int unsigned NumHarts = 1,
    parameter int unsigned Depth    = CommitLogEntries,
    parameter bit          CmpValue = 1'b1
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic                                            clear_i,
    input  logic                 [NumHarts-1:0]             exp_valid_i,
    input  commit_log_reg_item_t [NumHarts-1:0]             exp_item_i,
    output logic                 [NumHarts-1:0]             exp_ready_o,
    input  logic                 [NumHarts-1:0]             dut_valid_i,
    input  commit_log_reg_item_t [NumHarts-1:0]             dut_item_i,
    output logic                 [NumHarts-1:0]             dut_ready_o,
    output logic                 [NumHarts-1:0]             mismatch_o,
    output logic                                            first_err_valid_o,
    output logic [((NumHarts > 1) ? $clog2(NumHarts) : 1)-1:0] first_err_hart_o,
    output commit_log_reg_item_t                            first_err_exp_o,
    output commit_log_reg_item_t                            first_err_dut_o,
    output logic                 [NumHarts-1:0][31:0]       match_count_o,
    output logic                 [NumHarts-1:0][$clog2(Depth+1)-1:0] level_o,
    output cosim_chk_state_e     [NumHarts-1:0]             state_o
);
    localparam int unsigned HartW = (NumHarts > 1) ? $clog2(NumHarts) : 1;

    // Handshakes: a transfer happens in a cycle where valid and ready are both high;
    // ready never depends on valid, and a transfer in a clear cycle is discarded.
    logic                 [NumHarts-1:0]       full, empty, push, pop, pass, fail;
    commit_log_reg_item_t [NumHarts-1:0]       head;
    cosim_chk_state_e     [NumHarts-1:0]       state_q, state_d;
    logic                 [NumHarts-1:0]       mismatch_q;
    logic                 [NumHarts-1:0][31:0] match_count_q;
    logic                                      first_valid_q;
    logic                 [HartW-1:0]          first_hart_q;
    commit_log_reg_item_t                      first_exp_q, first_dut_q;
    int unsigned                               fail_idx;
    commit_log_reg_item_t                      fail_exp, fail_dut;

    for (genvar h = 0; h < NumHarts; h++) begin : g_hart
        cosim_log_fifo #(
            .Depth  (Depth),
            .item_t (commit_log_reg_item_t)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (clear_i),
            .push_i  (push[h]),
            .item_i  (exp_item_i[h]),
            .pop_i   (pop[h]),
            .head_o  (head[h]),
            .full_o  (full[h]),
            .empty_o (empty[h]),
            .level_o (level_o[h])
        );

        assign exp_ready_o[h] = !full[h];
        assign dut_ready_o[h] = !empty[h] && (state_q[h] == RUN);
        assign push[h]        = exp_valid_i[h] && exp_ready_o[h];
        assign pop[h]         = dut_valid_i[h] && dut_ready_o[h];
        assign pass[h]        = pop[h] && !clear_i && items_match(head[h], dut_item_i[h], CmpValue);
        assign fail[h]        = pop[h] && !clear_i && !items_match(head[h], dut_item_i[h], CmpValue);
    end

    always_comb begin
        state_d = state_q;
        for (int h = 0; h < int'(NumHarts); h++) begin
            unique case (state_q[h])
                RUN:     if (fail[h]) state_d[h] = HALT;
                HALT:    if (clear_i) state_d[h] = RUN;
                default: state_d[h] = RUN;
            endcase
            if (clear_i) state_d[h] = RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int h = 0; h < int'(NumHarts); h++) state_q[h] <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan downwards so the lowest failing hart wins a same-cycle tie.
    always_comb begin
        fail_idx = 0;
        fail_exp = '0;
        fail_dut = '0;
        for (int h = int'(NumHarts) - 1; h >= 0; h--) begin
            if (fail[h]) begin
                fail_idx = unsigned'(h);
                fail_exp = head[h];
                fail_dut = dut_item_i[h];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            mismatch_q    <= '0;
            match_count_q <= '0;
            first_valid_q <= 1'b0;
            first_hart_q  <= '0;
            first_exp_q   <= '0;
            first_dut_q   <= '0;
        end else begin
            mismatch_q <= mismatch_q | fail;
            for (int h = 0; h < int'(NumHarts); h++) begin
                if (pass[h] && (match_count_q[h] != 32'hFFFF_FFFF))
                    match_count_q[h] <= match_count_q[h] + 32'd1;
            end
            if (!first_valid_q && (|fail)) begin
                first_valid_q <= 1'b1;
                first_hart_q  <= HartW'(fail_idx);
                first_exp_q   <= fail_exp;
                first_dut_q   <= fail_dut;
            end
        end
    end

    assign mismatch_o        = mismatch_q;
    assign match_count_o     = match_count_q;
    assign first_err_valid_o = first_valid_q;
    assign first_err_hart_o  = first_hart_q;
    assign first_err_exp_o   = first_exp_q;
    assign first_err_dut_o   = first_dut_q;
    assign state_o           = state_q;
endmodule
